dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's data port (MemRW / Addr_out / Data_out / Data_in).
- Holds word-organised on-chip RAM plus a small MMIO page: a 64-bit cycle timer with compare-match interrupt, and a tohost halt register.
- Reads are combinational, because the core is single-cycle with no stall. Writes, the timer, the interrupt, halt and error reporting are clocked.

---
 rtl/dmem_responder_pkg.sv | 31 +++
 rtl/dmem_responder_mmio_timer.sv | 46 ++++
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus width, MMIO register
// offsets and the byte-lane merge helper used by every write path.
// Optional build macro: DMEM_MTIME_EN (enables the mtime/mtimecmp timer).
package dmem_responder_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned NBYTES  = XLEN / 8;
   localparam int unsigned MTIME_W = 64;

   // Byte offsets inside the 32-byte MMIO page (word aligned).
   localparam logic [4:0] MMIO_MTIME_LO    = 5'h00;
   localparam logic [4:0] MMIO_MTIME_HI    = 5'h04;
   localparam logic [4:0] MMIO_MTIMECMP_LO = 5'h08;
   localparam logic [4:0] MMIO_MTIMECMP_HI = 5'h0C;
   localparam logic [4:0] MMIO_TOHOST      = 5'h10;

   // Replace the byte lanes of old_val selected by be with those of new_val.
   function automatic logic [XLEN-1:0] merge_bytes(
      input logic [XLEN-1:0]   old_val,
      input logic [XLEN-1:0]   new_val,
      input logic [NBYTES-1:0] be
   );
      logic [XLEN-1:0] res;
      res = old_val;
      for (int i = 0; i < int'(NBYTES); i++) begin
         if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// 64-bit free-running cycle timer with compare register and registered
// compare-match interrupt. A write to either mtime half replaces that half
// and suppresses the increment for the cycle.
module dmem_responder_mmio_timer
   import dmem_responder_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_mtime_lo,
   input  logic                wr_mtime_hi,
   input  logic                wr_cmp_lo,
   input  logic                wr_cmp_hi,
   input  logic [XLEN-1:0]     wdata,
   input  logic [NBYTES-1:0]   be,
   output logic [MTIME_W-1:0]  mtime,
   output logic [MTIME_W-1:0]  mtimecmp,
   output logic                timer_irq
);

   // Timer, compare register and interrupt; compare uses pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         timer_irq <= 1'b0;
      end else begin
         timer_irq <= (mtime >= mtimecmp);

         if (wr_mtime_lo) begin
            mtime[XLEN-1:0] <= merge_bytes(mtime[XLEN-1:0], wdata, be);
         end else if (wr_mtime_hi) begin
            mtime[MTIME_W-1:XLEN] <= merge_bytes(mtime[MTIME_W-1:XLEN], wdata, be);
         end else begin
            mtime <= mtime + MTIME_W'(1);
         end

         if (wr_cmp_lo) begin
            mtimecmp[XLEN-1:0] <= merge_bytes(mtimecmp[XLEN-1:0], wdata, be);
         end
         if (wr_cmp_hi) begin
            mtimecmp[MTIME_W-1:XLEN] <= merge_bytes(mtimecmp[MTIME_W-1:XLEN], wdata, be);
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus a 32-byte MMIO page (optional timer,
// tohost halt register). Reads are combinational; all state is clocked.
// Optional build macro: DMEM_MTIME_EN (instantiates the mtime/mtimecmp timer;
// without it timer offsets read 0, ignore writes and timer_irq is tied 0).
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned     DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_wr,
   input  logic [XLEN-1:0]   addr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [NBYTES-1:0] be,
   output logic [XLEN-1:0]   rdata,
   output logic              timer_irq,
   output logic              halt,
   output logic [XLEN-1:0]   halt_code,
   output logic              bus_err
);

   localparam int unsigned   AW        = $clog2(DEPTH_WORDS);
   localparam logic [XLEN:0] RAM_BYTES = (XLEN+1)'(DEPTH_WORDS) << 2;

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic            ram_hit;
   logic            mmio_hit;
   logic [AW-1:0]   widx;
   logic [4:0]      moff;
   logic            wr_en;
   logic            ram_we;
   logic            tohost_we;
   logic [XLEN-1:0] tohost_merged;

   // Address decode and write qualification (halt blocks all writes).
   always_comb begin
      ram_hit       = ({1'b0, addr} < RAM_BYTES);
      mmio_hit      = (addr[XLEN-1:5] == MMIO_BASE[XLEN-1:5]);
      widx          = addr[AW+1:2];
      moff          = {addr[4:2], 2'b00};
      wr_en         = mem_wr && (be != '0) && !halt;
      ram_we        = wr_en && ram_hit;
      tohost_we     = wr_en && mmio_hit && (moff == MMIO_TOHOST);
      tohost_merged = merge_bytes(halt_code, wdata, be);
   end

`ifdef DMEM_MTIME_EN
   logic [MTIME_W-1:0] mtime;
   logic [MTIME_W-1:0] mtimecmp;

   dmem_responder_mmio_timer u_timer (
      .clk         (clk),
      .rst         (rst),
      .wr_mtime_lo (wr_en && mmio_hit && (moff == MMIO_MTIME_LO)),
      .wr_mtime_hi (wr_en && mmio_hit && (moff == MMIO_MTIME_HI)),
      .wr_cmp_lo   (wr_en && mmio_hit && (moff == MMIO_MTIMECMP_LO)),
      .wr_cmp_hi   (wr_en && mmio_hit && (moff == MMIO_MTIMECMP_HI)),
      .wdata       (wdata),
      .be          (be),
      .mtime       (mtime),
      .mtimecmp    (mtimecmp),
      .timer_irq   (timer_irq)
   );
`else
   assign timer_irq = 1'b0;
`endif

   // RAM byte-lane writes; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst && ram_we) begin
         for (int i = 0; i < int'(NBYTES); i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Combinational read mux; unmapped and reserved offsets return 0.
   always_comb begin
      rdata = '0;
      if (ram_hit) begin
         rdata = mem[widx];
      end else if (mmio_hit) begin
         case (moff)
`ifdef DMEM_MTIME_EN
            MMIO_MTIME_LO:    rdata = mtime[XLEN-1:0];
            MMIO_MTIME_HI:    rdata = mtime[MTIME_W-1:XLEN];
            MMIO_MTIMECMP_LO: rdata = mtimecmp[XLEN-1:0];
            MMIO_MTIMECMP_HI: rdata = mtimecmp[MTIME_W-1:XLEN];
`endif
            MMIO_TOHOST:      rdata = halt_code;
            default:          rdata = '0;
         endcase
      end
   end

   // tohost/halt register and one-cycle unmapped-access flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         halt      <= 1'b0;
         halt_code <= '0;
         bus_err   <= 1'b0;
      end else begin
         bus_err <= !ram_hit && !mmio_hit;
         if (tohost_we && (tohost_merged != '0)) begin
            halt_code <= tohost_merged;
            halt      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder.
// Build with +define+DMEM_MTIME_EN to exercise the timer checks.
module tb_dmem_responder;

   localparam logic [31:0] MB = 32'hFFFF_0000;

   logic        clk;
   logic        rst;
   logic        mem_wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        timer_irq;
   logic        halt;
   logic [31:0] halt_code;
   logic        bus_err;

   int vectors    = 0;
   int miscompares = 0;

   dmem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .mem_wr    (mem_wr),
      .addr      (addr),
      .wdata     (wdata),
      .be        (be),
      .rdata     (rdata),
      .timer_irq (timer_irq),
      .halt      (halt),
      .halt_code (halt_code),
      .bus_err   (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_wr = 1'b0;
      addr   = 32'h0;
      wdata  = 32'h0;
      be     = 4'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      mem_wr = 1'b1;
      addr   = a;
      wdata  = d;
      be     = b;
      tick();
      idle();
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      mem_wr = 1'b0;
      addr   = a;
      be     = 4'h0;
      #1;
      chk(tag, 64'(rdata), 64'(exp));
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      idle();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_irq", 64'(timer_irq), 64'h0);
      chk("rst_halt", 64'(halt), 64'h0);
      chk("rst_code", 64'(halt_code), 64'h0);
      chk("rst_buserr", 64'(bus_err), 64'h0);
      tick();
      tick();
      rst = 1'b1;

      // RAM full-word and byte-lane writes
      wr(32'h40, 32'hDEAD_BEEF, 4'hF);
      peek("ram40", 32'h40, 32'hDEAD_BEEF);
      chk("irq_idle", 64'(timer_irq), 64'h0);
      chk("halt_idle", 64'(halt), 64'h0);
      wr(32'h44, 32'h1122_3344, 4'hF);
      wr(32'h44, 32'h0000_00AA, 4'h1);
      peek("ram44_be1", 32'h44, 32'h1122_33AA);
      wr(32'h44, 32'hFFFF_FFFF, 4'h0);
      peek("ram44_be0", 32'h44, 32'h1122_33AA);
      wr(32'h48, 32'hAABB_CCDD, 4'hF);
      wr(32'h48, 32'h1122_3344, 4'h6);
      peek("ram48_be6", 32'h48, 32'hAA22_33DD);
      wr(32'hFFC, 32'h0BAD_CAFE, 4'hF);
      peek("ram_top", 32'hFFC, 32'h0BAD_CAFE);
      tick();
      chk("ram_top_err", 64'(bus_err), 64'h0);

      // unmapped read and write
      wr(32'h0, 32'hCAFE_F00D, 4'hF);
      peek("unm_rd", 32'h8000_0000, 32'h0);
      chk("unm_err_pre", 64'(bus_err), 64'h0);
      tick();
      chk("unm_rd_err", 64'(bus_err), 64'h1);
      idle();
      tick();
      chk("unm_rd_err_end", 64'(bus_err), 64'h0);
      wr(32'h8000_0000, 32'h1234_5678, 4'hF);
      chk("unm_wr_err", 64'(bus_err), 64'h1);
      peek("unm_wr_ram0", 32'h0, 32'hCAFE_F00D);
      chk("unm_wr_code", 64'(halt_code), 64'h0);
      tick();
      chk("unm_wr_err_end", 64'(bus_err), 64'h0);
      wr(32'h1000, 32'h0000_0099, 4'hF);
      chk("past_ram_err", 64'(bus_err), 64'h1);
      peek("past_ram_alias", 32'h0, 32'hCAFE_F00D);
      peek("below_mmio", MB - 32'h4, 32'h0);
      tick();
      chk("below_mmio_err", 64'(bus_err), 64'h1);
      wr(MB + 32'h14, 32'hFFFF_FFFF, 4'hF);
      chk("rsvd_err", 64'(bus_err), 64'h0);
      peek("rsvd_rd", MB + 32'h14, 32'h0);

`ifndef DMEM_MTIME_EN
      // timer absent: offsets read 0 and ignore writes
      wr(MB, 32'h0000_0005, 4'hF);
      peek("notimer_lo", MB, 32'h0);
      peek("notimer_cmp", MB + 32'h8, 32'h0);
      chk("notimer_irq", 64'(timer_irq), 64'h0);
`endif

      // tohost / halt
      wr(MB + 32'h10, 32'h0, 4'hF);
      chk("tohost0_halt", 64'(halt), 64'h0);
      chk("tohost0_code", 64'(halt_code), 64'h0);
      wr(MB + 32'h10, 32'h1, 4'hF);
      chk("halt_set", 64'(halt), 64'h1);
      chk("halt_code", 64'(halt_code), 64'h1);
      wr(32'h0, 32'h0000_0055, 4'hF);
      peek("halt_ram0", 32'h0, 32'hCAFE_F00D);
      wr(MB + 32'h10, 32'h7, 4'hF);
      chk("halt_code_hold", 64'(halt_code), 64'h1);
      peek("tohost_rd", MB + 32'h10, 32'h1);

      // asynchronous reset mid-cycle
      rst = 1'b0;
      #1;
      chk("async_halt", 64'(halt), 64'h0);
      chk("async_code", 64'(halt_code), 64'h0);
      tick();
      rst = 1'b1;
      idle();
      peek("ram_kept", 32'h40, 32'hDEAD_BEEF);

`ifdef DMEM_MTIME_EN
      // compare-match interrupt
      wr(MB + 32'h8, 32'd20, 4'hF);
      wr(MB + 32'hC, 32'h0, 4'hF);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         addr = MB;
         #1;
         if (rdata == 32'd20) found = 1'b1;
         else tick();
      end
      chk("irq_reach20", 64'(found), 64'h1);
      chk("irq_at20", 64'(timer_irq), 64'h0);
      tick();
      chk("irq_rise", 64'(timer_irq), 64'h1);
      wr(MB + 32'hC, 32'h1, 4'hF);
      chk("irq_wrcycle", 64'(timer_irq), 64'h1);
      tick();
      chk("irq_drop", 64'(timer_irq), 64'h0);

      // mtime write suppression and lo->hi carry
      wr(MB, 32'hFFFF_FFFE, 4'hF);
      wr(MB + 32'h4, 32'h0, 4'hF);
      peek("mt_lo_wr", MB, 32'hFFFF_FFFE);
      peek("mt_hi_wr", MB + 32'h4, 32'h0);
      tick();
      tick();
      tick();
      peek("mt_hi_carry", MB + 32'h4, 32'h1);
      peek("mt_lo_carry", MB, 32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
